ahb_ext_sram: RTL and testbench

AHB_EXT_SRAM -- requirements
Module: ahb_ext_sram

---
 rtl/ahb_ext_sram_pkg.sv | 19 +
 rtl/ahbext_bram.sv | 31 +++
 rtl/ahb_ext_sram.sv | 110 +++++++++++
 tb/tb_ahb_ext_sram.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_ext_sram_pkg.sv
// Shared package cvw: FSM state encoding and AHB HTRANS encodings.
// Imported by ahb_ext_sram and ahbext_bram.
// No ports; types and constants only.
package cvw;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_XFER = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/ahbext_bram.sv
// Word-organised storage: asynchronous read, synchronous byte-enabled write.
// Ports: clk, we (write enable), idx (word index for both read and write),
//        wdata/wstrb (write data and byte lanes), rdata (combinational read).
// Contents are never reset.
module ahbext_bram
  import cvw::*;
#(
  parameter int AHBW      = 64,
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [AHBW-1:0]      wdata,
  input  logic [AHBW/8-1:0]    wstrb,
  output logic [AHBW-1:0]      rdata
);

  logic [AHBW-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < AHBW/8; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_ext_sram.sv
// AHB subordinate fronting an on-chip SRAM region with optional wait states.
// Ports: clk/reset (sync, active-high), AHB address/data-phase inputs,
//        HRDATAEXT/HREADYEXT/HRESPEXT responses.
// Optional macro AHBEXT_ERR_RESP_EN: out-of-range accesses get a two-cycle ERROR
// response instead of wrapping modulo the array depth.
module ahb_ext_sram
  import cvw::*;
#(
  parameter int          AHBW        = 64,
  parameter int          PA_BITS     = 56,
  parameter logic [63:0] BASE        = 64'h8000_0000,
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               HSELEXT,
  input  logic [PA_BITS-1:0] HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [AHBW-1:0]    HWDATA,
  input  logic [AHBW/8-1:0]  HWSTRB,
  input  logic               HREADY,
  output logic [AHBW-1:0]    HRDATAEXT,
  output logic               HREADYEXT,
  output logic               HRESPEXT
);

  localparam int                 LB      = $clog2(AHBW/8);
  localparam logic [PA_BITS-1:0] BASE_PA = BASE[PA_BITS-1:0];

  state_t               state, nxt;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 wr_q, rng_q;
  logic [PA_BITS-1:0]   off;
  logic                 in_rng, accept, we;
  logic [AHBW-1:0]      rdata;
  state_t               dest;

  assign off    = HADDR - BASE_PA;
  assign in_rng = (HADDR >= BASE_PA) && (off[PA_BITS-1:ADDR_BITS+LB] == '0);

  // A new address phase may only be taken while this subordinate is not stalling.
  assign accept = HSELEXT & HTRANS[1] & HREADY &
                  ((state == S_IDLE) | (state == S_XFER) | (state == S_ERR2));

  always_comb begin
    dest = (WAIT_STATES > 0) ? S_WAIT : S_XFER;
`ifdef AHBEXT_ERR_RESP_EN
    if (!in_rng) dest = S_ERR1;
`endif
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_XFER, S_ERR2: nxt = accept ? dest : S_IDLE;
      S_WAIT:                 if (cnt == 4'd0) nxt = S_XFER;
      S_ERR1:                 nxt = S_ERR2;
      default:                nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      idx_q <= '0;
      wr_q  <= 1'b0;
      rng_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        idx_q <= off[ADDR_BITS+LB-1:LB];
        wr_q  <= HWRITE;
        rng_q <= in_rng;
      end
      if (accept && dest == S_WAIT) cnt <= 4'(WAIT_STATES - 1);
      else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  // XFER is only reachable for in-range beats when error responses are enabled,
  // so the write enable needs no range qualifier. Reset suppresses a pending commit.
  assign we = (state == S_XFER) & wr_q & ~reset;

  ahbext_bram #(.AHBW(AHBW), .ADDR_BITS(ADDR_BITS)) u_bram (
    .clk   (clk),
    .we    (we),
    .idx   (idx_q),
    .wdata (HWDATA),
    .wstrb (HWSTRB),
    .rdata (rdata)
  );

  assign HRDATAEXT = (((state == S_WAIT) | (state == S_XFER)) & ~wr_q) ? rdata : '0;
  assign HREADYEXT = ~((state == S_WAIT) | (state == S_ERR1));
`ifdef AHBEXT_ERR_RESP_EN
  assign HRESPEXT  = (state == S_ERR1) | (state == S_ERR2);
`else
  assign HRESPEXT  = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, HSIZE, HBURST, HTRANS[0], rng_q, off[LB-1:0]};

endmodule

// File: tb/tb_ahb_ext_sram.sv
module tb_ahb_ext_sram;

  localparam logic [55:0] B = 56'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT 0: zero wait states
  logic        rst0, sel0, write0, hrf0;
  logic [55:0] addr0;
  logic [1:0]  trans0;
  logic [63:0] wdata0, rdata0;
  logic [7:0]  wstrb0;
  logic        rdy0, resp0, hready0;
  assign hready0 = rdy0 & hrf0;

  // DUT 3: three wait states
  logic        rst3, sel3, write3;
  logic [55:0] addr3;
  logic [1:0]  trans3;
  logic [63:0] wdata3, rdata3;
  logic [7:0]  wstrb3;
  logic        rdy3, resp3;

  ahb_ext_sram u0 (
    .clk(clk), .reset(rst0), .HSELEXT(sel0), .HADDR(addr0), .HTRANS(trans0),
    .HWRITE(write0), .HSIZE(3'd3), .HBURST(3'd0), .HWDATA(wdata0), .HWSTRB(wstrb0),
    .HREADY(hready0), .HRDATAEXT(rdata0), .HREADYEXT(rdy0), .HRESPEXT(resp0)
  );

  ahb_ext_sram #(.WAIT_STATES(3)) u3 (
    .clk(clk), .reset(rst3), .HSELEXT(sel3), .HADDR(addr3), .HTRANS(trans3),
    .HWRITE(write3), .HSIZE(3'd3), .HBURST(3'd0), .HWDATA(wdata3), .HWSTRB(wstrb3),
    .HREADY(rdy3), .HRDATAEXT(rdata3), .HREADYEXT(rdy3), .HRESPEXT(resp3)
  );

  // ---------------- DUT 0 helpers ----------------
  task automatic wr0(input logic [55:0] a, input logic [63:0] d, input logic [7:0] s);
    @(posedge clk); #1 sel0 = 1; trans0 = 2'b10; write0 = 1; addr0 = a;
    @(posedge clk); #1 sel0 = 0; trans0 = 2'b00; write0 = 0; wdata0 = d; wstrb0 = s;
  endtask

  task automatic rd0(input logic [55:0] a, input logic [63:0] exp, input string nm);
    @(posedge clk); #1 sel0 = 1; trans0 = 2'b10; write0 = 0; addr0 = a;
    @(posedge clk); #1 sel0 = 0; trans0 = 2'b00;
    @(negedge clk);
    checks++;
    if (rdata0 !== exp || rdy0 !== 1'b1 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rdata=%h rdy=%b resp=%b, expected rdata=%h rdy=1 resp=0",
               nm, rdata0, rdy0, resp0, exp);
    end
  endtask

  // ---------------- DUT 3 helpers ----------------
  task automatic wr3(input logic [55:0] a, input logic [63:0] d);
    @(posedge clk); #1 sel3 = 1; trans3 = 2'b10; write3 = 1; addr3 = a;
    @(posedge clk); #1 sel3 = 0; trans3 = 2'b00; write3 = 0; wdata3 = d; wstrb3 = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy3 === 1'b1) break;
    end
  endtask

  task automatic rd3(input logic [55:0] a, input logic [63:0] exp, input string nm);
    int low;
    low = 0;
    @(posedge clk); #1 sel3 = 1; trans3 = 2'b10; write3 = 0; addr3 = a;
    @(posedge clk); #1 sel3 = 0; trans3 = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy3 === 1'b1) break;
      low++;
    end
    checks++;
    if (low != 3 || rdy3 !== 1'b1 || rdata3 !== exp || resp3 !== 1'b0) begin
      errors++;
      $display("FAIL %s: got low_cycles=%0d rdy=%b rdata=%h resp=%b, expected low_cycles=3 rdy=1 rdata=%h resp=0",
               nm, low, rdy3, rdata3, resp3, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst0 = 1; rst3 = 1;
    sel0 = 0; trans0 = 0; write0 = 0; addr0 = 0; wdata0 = 0; wstrb0 = 0; hrf0 = 1;
    sel3 = 0; trans3 = 0; write3 = 0; addr3 = 0; wdata3 = 0; wstrb3 = 0;
    repeat (2) @(posedge clk);
    #1 rst0 = 0; rst3 = 0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || resp0 !== 1'b0 || rdata0 !== 64'h0) begin
      errors++;
      $display("FAIL reset_u0: got rdy=%b resp=%b rdata=%h, expected 1 0 0", rdy0, resp0, rdata0);
    end
    checks++;
    if (rdy3 !== 1'b1 || resp3 !== 1'b0 || rdata3 !== 64'h0) begin
      errors++;
      $display("FAIL reset_u3: got rdy=%b resp=%b rdata=%h, expected 1 0 0", rdy3, resp3, rdata3);
    end
  endtask

  task automatic test_write_read;
    wr0(B + 56'h10, 64'h1122334455667788, 8'hFF);
    rd0(B + 56'h10, 64'h1122334455667788, "write_read_full");
    // Data bus must return to zero once the read data phase is over.
    @(negedge clk);
    checks++;
    if (rdata0 !== 64'h0) begin
      errors++;
      $display("FAIL rdata_idle_zero: got %h, expected 0", rdata0);
    end
  endtask

  task automatic test_strobes;
    wr0(B + 56'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rd0(B + 56'h10, 64'h11223344AAAAAAAA, "strobe_low_half");
    wr0(B + 56'h10, 64'h5555555555555555, 8'h81);
    rd0(B + 56'h10, 64'h55223344AAAAAA55, "strobe_ends");
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1 sel0 = 1; trans0 = 2'b10; write0 = 1; addr0 = B + 56'h28;
    @(posedge clk); #1 wdata0 = 64'hCAFEF00DDEADBEEF; wstrb0 = 8'hFF; write0 = 0; addr0 = B + 56'h28;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_stall: got rdy=%b, expected 1", rdy0);
    end
    @(posedge clk); #1 sel0 = 0; trans0 = 2'b00;
    @(negedge clk);
    checks++;
    if (rdata0 !== 64'hCAFEF00DDEADBEEF || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read: got rdata=%h rdy=%b, expected cafef00ddeadbeef 1", rdata0, rdy0);
    end
  endtask

  task automatic test_idle_busy_hready;
    // BUSY transfer while selected: zero-wait OKAY, no state change
    @(posedge clk); #1 sel0 = 1; trans0 = 2'b01; write0 = 1; addr0 = B + 56'h10;
    @(posedge clk); #1 sel0 = 0; trans0 = 2'b00; write0 = 0; wdata0 = 64'h0; wstrb0 = 8'hFF;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || resp0 !== 1'b0) begin
      errors++;
      $display("FAIL busy_okay: got rdy=%b resp=%b, expected 1 0", rdy0, resp0);
    end
    // NONSEQ write with HREADY low must not be accepted
    @(posedge clk); #1 sel0 = 1; trans0 = 2'b10; write0 = 1; addr0 = B + 56'h10; hrf0 = 0;
    @(posedge clk); #1 sel0 = 0; trans0 = 2'b00; write0 = 0; hrf0 = 1; wdata0 = 64'h0; wstrb0 = 8'hFF;
    rd0(B + 56'h10, 64'h55223344AAAAAA55, "no_accept_unchanged");
  endtask

  task automatic test_range;
    wr0(B, 64'h0123456789ABCDEF, 8'hFF);
`ifdef AHBEXT_ERR_RESP_EN
    @(posedge clk); #1 sel0 = 1; trans0 = 2'b10; write0 = 0; addr0 = B + 56'h8000;
    @(posedge clk); #1 sel0 = 0; trans0 = 2'b00;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0 || resp0 !== 1'b1 || rdata0 !== 64'h0) begin
      errors++;
      $display("FAIL err1: got rdy=%b resp=%b rdata=%h, expected 0 1 0", rdy0, resp0, rdata0);
    end
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || resp0 !== 1'b1 || rdata0 !== 64'h0) begin
      errors++;
      $display("FAIL err2: got rdy=%b resp=%b rdata=%h, expected 1 1 0", rdy0, resp0, rdata0);
    end
    rd0(B, 64'h0123456789ABCDEF, "err_storage_unchanged");
`else
    rd0(B + 56'h8000, 64'h0123456789ABCDEF, "wrap_modulo_depth");
`endif
  endtask

  task automatic test_wait_states;
    wr3(B + 56'h10, 64'h1122334455667788);
    rd3(B + 56'h10, 64'h1122334455667788, "wait3_read");
  endtask

  task automatic test_reset_during_wait;
    wr3(B + 56'h20, 64'h0F0E0D0C0B0A0908);
    @(posedge clk); #1 sel3 = 1; trans3 = 2'b10; write3 = 1; addr3 = B + 56'h20;
    @(posedge clk); #1 sel3 = 0; trans3 = 2'b00; write3 = 0; wdata3 = 64'hFFFFFFFFFFFFFFFF; wstrb3 = 8'hFF;
    @(negedge clk);
    checks++;
    if (rdy3 !== 1'b0) begin
      errors++;
      $display("FAIL in_wait: got rdy=%b, expected 0", rdy3);
    end
    rst3 = 1;
    @(posedge clk); #1 rst3 = 0;
    @(negedge clk);
    checks++;
    if (rdy3 !== 1'b1 || resp3 !== 1'b0 || rdata3 !== 64'h0) begin
      errors++;
      $display("FAIL reset_abandon: got rdy=%b resp=%b rdata=%h, expected 1 0 0", rdy3, resp3, rdata3);
    end
    rd3(B + 56'h20, 64'h0F0E0D0C0B0A0908, "reset_no_commit");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_back_to_back();
    test_idle_busy_hready();
    test_range();
    test_wait_states();
    test_reset_during_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
